// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external Mem FIFO between NUM_REQ producers and a single
//   valid/ready consumer. The write side round-robins producer requests into
//   the FIFO write port and stops granting while the FIFO is full. The read
//   side keeps one output slot filled, hiding Mem's registered read latency.
//   It never reads an empty FIFO and never writes a full one.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   req_i           per-producer request, held with data until granted
//   data_i          producer words, producer k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o           one-hot/zero combinational grant; word is written this cycle
//   out_valid_o     output slot holds a word
//   out_ready_i     consumer accepts the word in the slot
//   out_data_o      consumer word, straight from Mem.Data_o
//   mem_wen_o       Mem.WEnable_i
//   mem_ren_o       Mem.REnable_i
//   mem_wdata_o     Mem.Data_i (zero when nothing is granted)
//   mem_data_i      Mem.Data_o
//   mem_empty_i     Mem.Empty_o
//   mem_full_i      Mem.Full_o
//   level_o         FIFO occupancy, 0..2**ADDR_WIDTH
module mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          mem_wen_o,
  output logic                          mem_ren_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_data_i,
  input  logic                          mem_empty_i,
  input  logic                          mem_full_i,
  output logic [ADDR_WIDTH:0]           level_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] DEPTH = LVL_W'(1) << ADDR_WIDTH;

  // Same bit layout as data_i, indexed per producer.
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] words;
  assign words = data_i;

  logic [PTR_W-1:0]      rr;
  logic [PTR_W-1:0]      sel;
  logic [PTR_W:0]        idx;
  logic                  found;
  logic [NUM_REQ-1:0]    gnt;
  logic                  wen;
  logic                  ren;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  valid;
  logic [LVL_W-1:0]      level;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. Scan rr, rr+1, ... (mod NUM_REQ) and grant the
  // first requester. idx carries one spare bit so rr+i never overflows before
  // the modulo wrap. Full and reset suppress every grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt   = '0;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    if (!reset && !mem_full_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = {1'b0, rr} + (PTR_W+1)'(i);
        if (idx >= (PTR_W+1)'(NUM_REQ))
          idx = idx - (PTR_W+1)'(NUM_REQ);
        if (!found && req_i[idx[PTR_W-1:0]]) begin
          found                 = 1'b1;
          gnt[idx[PTR_W-1:0]]   = 1'b1;
          sel                   = idx[PTR_W-1:0];
        end
      end
    end
  end

  assign wen = |gnt;

  // One-hot grant lets the write mux be a plain AND-OR; no grant gives zero.
  always_comb begin
    wdata = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt[k])
        wdata = wdata | words[k];
  end

  // After granting producer k, priority starts just past k.
  always_ff @(posedge clk) begin
    if (reset)
      rr <= '0;
    else if (wen)
      rr <= (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read side. A read is issued whenever the slot is empty or being emptied this
  // cycle. Mem.Data_o updates on the next edge, which is exactly when the slot
  // becomes valid. While the consumer stalls, no read is issued, so Mem.Data_o
  // and therefore out_data_o hold still.
  // ---------------------------------------------------------------------------
  assign ren = !reset && !mem_empty_i && (!valid || out_ready_i);

  always_ff @(posedge clk) begin
    if (reset)
      valid <= 1'b0;
    else if (ren)
      valid <= 1'b1;
    else if (valid && out_ready_i)
      valid <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Occupancy of Mem itself (the output slot is not counted).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      level <= '0;
    else begin
      case ({wen, ren})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(ren && level == '0))
        else $error("mem_arbiter: read issued with level 0");
      assert (!(wen && level == DEPTH))
        else $error("mem_arbiter: write issued with FIFO at capacity");
    end
  end
`endif

  assign gnt_o       = gnt;
  assign mem_wen_o   = wen;
  assign mem_ren_o   = ren;
  assign mem_wdata_o = wdata;
  assign out_valid_o = valid;
  assign out_data_o  = mem_data_i;
  assign level_o     = level;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives mem_arbiter next to a behavioural Mem FIFO. Each cycle's
//   outputs are compared with a queue-based reference model of the
//   arbiter: round-robin pointer, word order, output slot and occupancy.
module tb_mem_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            mem_wen;
  logic            mem_ren;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_data = '0;
  logic            mem_empty;
  logic            mem_full;
  logic [AW:0]     level;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_i(req), .data_i(data), .gnt_o(gnt),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .mem_wen_o(mem_wen), .mem_ren_o(mem_ren), .mem_wdata_o(mem_wdata),
    .mem_data_i(mem_data), .mem_empty_i(mem_empty), .mem_full_i(mem_full),
    .level_o(level)
  );

  // ---- behavioural Mem: registered read, flags from an occupancy count ----
  logic [DW-1:0] mem_arr [DEPTH];
  int wp = 0, rp = 0, cnt = 0;
  assign mem_empty = (cnt == 0);
  assign mem_full  = (cnt == DEPTH);

  always @(posedge clk) begin
    if (reset) begin
      wp <= 0; rp <= 0; cnt <= 0;
    end else begin
      if (mem_wen && !mem_full) begin
        mem_arr[wp] <= mem_wdata;
        wp <= (wp + 1) % DEPTH;
      end
      if (mem_ren && !mem_empty) begin
        mem_data <= mem_arr[rp];
        rp <= (rp + 1) % DEPTH;
      end
      cnt <= cnt + ((mem_wen && !mem_full) ? 1 : 0) - ((mem_ren && !mem_empty) ? 1 : 0);
    end
  end

  // ---- producer data ----
  logic [DW-1:0] dv [N];
  bit rand_data = 1'b0;
  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) data[k*DW +: DW] = dv[k];
  end

  // ---- reference model ----
  int            m_rr = 0;
  int            m_level = 0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_out = '0;
  logic [DW-1:0] sb [$];
  logic [N-1:0]  last_g = '0;

  function automatic logic [N-1:0] exp_gnt();
    int k;
    if (reset || mem_full) return '0;
    for (int i = 0; i < N; i++) begin
      k = (m_rr + i) % N;
      if (req[k]) return N'(1) << k;
    end
    return '0;
  endfunction

  function automatic logic exp_ren();
    return !reset && !mem_empty && (!m_valid || out_ready);
  endfunction

  function automatic logic [DW-1:0] exp_wdata();
    logic [N-1:0] g;
    g = exp_gnt();
    for (int k = 0; k < N; k++) if (g[k]) return dv[k];
    return '0;
  endfunction

  // Advance the model across the coming clock edge (called at negedge).
  task automatic step_model();
    logic [N-1:0] g;
    logic r;
    g = exp_gnt();
    r = exp_ren();
    last_g = g;
    if (reset) begin
      m_rr = 0; m_level = 0; m_valid = 1'b0; sb.delete();
      return;
    end
    for (int k = 0; k < N; k++)
      if (g[k]) begin
        sb.push_back(dv[k]);
        m_rr = (k + 1) % N;
        m_level++;
      end
    if (r && sb.size() > 0) begin
      m_out = sb.pop_front();
      m_valid = 1'b1;
      m_level--;
    end else if (m_valid && out_ready)
      m_valid = 1'b0;
  endtask

  // Cross the edge; granted producers then present a fresh word.
  task automatic advance();
    @(posedge clk);
    #1;
    if (rand_data)
      for (int k = 0; k < N; k++) if (last_g[k]) dv[k] = DW'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; req = '1; out_ready = 1'b0;
    for (int k = 0; k < N; k++) dv[k] = DW'(k);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt got=%b want=0", gnt); end
      vectors++; if (mem_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen got=%b want=0", mem_wen); end
      vectors++; if (mem_ren !== 1'b0) begin miscompares++; $display("FAIL reset_ren got=%b want=0", mem_ren); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      vectors++; if (level !== '0) begin miscompares++; $display("FAIL reset_level got=%0d want=0", level); end
      step_model();
      advance();
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    req = 4'b1111; out_ready = 1'b0; rand_data = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++; if (gnt !== (N'(1) << (c % N))) begin miscompares++; $display("FAIL rr_order cyc=%0d got=%b want=%b", c, gnt, N'(1) << (c % N)); end
      vectors++; if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      vectors++; if (mem_wdata !== DW'(c % N)) begin miscompares++; $display("FAIL rr_wdata cyc=%0d got=%0d want=%0d", c, mem_wdata, c % N); end
      vectors++; if (level !== (AW+1)'(m_level)) begin miscompares++; $display("FAIL rr_level cyc=%0d got=%0d want=%0d", c, level, m_level); end
      step_model();
      advance();
    end
    rand_data = 1'b1;
    for (int k = 0; k < N; k++) dv[k] = DW'($urandom);
  endtask

  task automatic test_fill();
    bit reached = 1'b0;
    req = '1; out_ready = 1'b0;
    for (int c = 0; c < 80 && !reached; c++) begin
      @(negedge clk);
      vectors++; if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL fill_gnt got=%b want=%b", gnt, exp_gnt()); end
      vectors++; if (mem_wdata !== exp_wdata()) begin miscompares++; $display("FAIL fill_wdata got=%h want=%h", mem_wdata, exp_wdata()); end
      vectors++; if (level !== (AW+1)'(m_level)) begin miscompares++; $display("FAIL fill_level got=%0d want=%0d", level, m_level); end
      if (m_level == DEPTH) reached = 1'b1;
      step_model();
      advance();
    end
    vectors++; if (!reached) begin miscompares++; $display("FAIL fill_timeout got=level %0d want=%0d", level, DEPTH); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (mem_full !== 1'b1 || level !== (AW+1)'(DEPTH)) begin miscompares++; $display("FAIL fill_full got=full %b level %0d want=full 1 level %0d", mem_full, level, DEPTH); end
      vectors++; if (gnt !== '0 || mem_wen !== 1'b0) begin miscompares++; $display("FAIL fill_no_write got=gnt %b wen %b want=0", gnt, mem_wen); end
      step_model();
      advance();
    end
  endtask

  task automatic test_drain();
    int expected_words;
    int accepted = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    expected_words = sb.size() + (m_valid ? 1 : 0);
    req = '0;
    for (int c = 0; c < 150 && (m_valid || sb.size() > 0); c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL drain_valid got=%b want=%b", out_valid, m_valid); end
      if (m_valid) begin
        vectors++; if (out_data !== m_out) begin miscompares++; $display("FAIL drain_order got=%h want=%h", out_data, m_out); end
      end
      if (stalled) begin
        vectors++; if (out_data !== held) begin miscompares++; $display("FAIL drain_stable got=%h want=%h", out_data, held); end
      end
      vectors++; if (mem_ren !== exp_ren()) begin miscompares++; $display("FAIL drain_ren got=%b want=%b", mem_ren, exp_ren()); end
      vectors++; if (mem_ren && mem_empty) begin miscompares++; $display("FAIL drain_illegal_read got=ren 1 empty 1 want=no read"); end
      stalled = m_valid && !out_ready;
      held = out_data;
      if (m_valid && out_ready) accepted++;
      step_model();
      advance();
    end
    vectors++; if (accepted != expected_words) begin miscompares++; $display("FAIL drain_count got=%0d want=%0d", accepted, expected_words); end
  endtask

  task automatic test_steady();
    int first_g = -100, first_v = -100;
    req = 4'b0001; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (first_g < 0 && exp_gnt() != '0) first_g = c;
      if (first_v < 0 && out_valid === 1'b1) first_v = c;
      vectors++; if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL steady_gnt got=%b want=%b", gnt, exp_gnt()); end
      vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL steady_valid cyc=%0d got=%b want=%b", c, out_valid, m_valid); end
      if (m_valid) begin
        vectors++; if (out_data !== m_out) begin miscompares++; $display("FAIL steady_data got=%h want=%h", out_data, m_out); end
      end
      if (first_g >= 0 && c > first_g) begin
        vectors++; if (level !== (AW+1)'(m_level) || level < 1 || level > 2) begin miscompares++; $display("FAIL steady_level got=%0d want=%0d (1..2)", level, m_level); end
      end
      if (first_v >= 0) begin
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL steady_rate cyc=%0d got=%b want=1", c, out_valid); end
      end
      step_model();
      advance();
    end
    vectors++; if (first_v - first_g != 2) begin miscompares++; $display("FAIL steady_latency got=%0d want=2", first_v - first_g); end
  endtask

  task automatic test_reset_mid();
    bit ready_pt = 1'b0;
    req = 4'b1111; out_ready = 1'b0;
    for (int c = 0; c < 20 && !ready_pt; c++) begin
      @(negedge clk);
      vectors++; if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL mid_gnt got=%b want=%b", gnt, exp_gnt()); end
      vectors++; if (level !== (AW+1)'(m_level)) begin miscompares++; $display("FAIL mid_level got=%0d want=%0d", level, m_level); end
      step_model();
      if (m_level == 5 && m_valid) ready_pt = 1'b1;
      advance();
    end
    vectors++; if (!ready_pt) begin miscompares++; $display("FAIL mid_setup_timeout got=level %0d want=5", level); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (gnt !== '0 || mem_wen !== 1'b0) begin miscompares++; $display("FAIL mid_reset_write got=gnt %b wen %b want=0", gnt, mem_wen); end
    vectors++; if (mem_ren !== 1'b0) begin miscompares++; $display("FAIL mid_reset_read got=%b want=0 (empty=%b)", mem_ren, mem_empty); end
    step_model();
    advance();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || level !== '0) begin miscompares++; $display("FAIL mid_after got=valid %b level %0d want=0 0", out_valid, level); end
    vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL mid_next_gnt got=%b want=0001", gnt); end
    step_model();
    advance();
  endtask

  task automatic test_random();
    int pct;
    for (int c = 0; c < 400; c++) begin
      case (c / 100)
        0: pct = 90;
        1: pct = 5;
        2: pct = 50;
        default: pct = 100;
      endcase
      req = N'($urandom);
      out_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      vectors++; if (gnt !== exp_gnt()) begin miscompares++; $display("FAIL rand_gnt cyc=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      vectors++; if (mem_wen !== (|exp_gnt()) || mem_wdata !== exp_wdata()) begin miscompares++; $display("FAIL rand_write cyc=%0d got=%b/%h want=%b/%h", c, mem_wen, mem_wdata, |exp_gnt(), exp_wdata()); end
      vectors++; if (mem_ren !== exp_ren()) begin miscompares++; $display("FAIL rand_ren cyc=%0d got=%b want=%b", c, mem_ren, exp_ren()); end
      vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, out_valid, m_valid); end
      if (m_valid) begin
        vectors++; if (out_data !== m_out) begin miscompares++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, out_data, m_out); end
      end
      vectors++; if (level !== (AW+1)'(m_level)) begin miscompares++; $display("FAIL rand_level cyc=%0d got=%0d want=%0d", c, level, m_level); end
      vectors++; if ((mem_wen && mem_full) || (mem_ren && mem_empty)) begin miscompares++; $display("FAIL rand_illegal cyc=%0d got=wen %b full %b ren %b empty %b want=no access", c, mem_wen, mem_full, mem_ren, mem_empty); end
      step_model();
      advance();
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0;
    for (int k = 0; k < N; k++) dv[k] = '0;
    test_reset();
    test_round_robin();
    test_fill();
    test_drain();
    test_steady();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
